// File: rtl/vga_pkg.sv
// Package: vga_pkg
// Shared constants and types for the VGA scan-out path.
//   - Timing: H_ACTIVE, H_TOTAL, V_ACTIVE, V_TOTAL.
//   - Widths: DATA_W (RGB555 pixel), ADDR_W (bank address), LINE_W (line number), POS_W (timing counters).
//   - rgb555_t: packed struct giving the r/g/b field slices of a pixel word.
//   - fill_state_e: 2-bit encoding of the line-fetch FSM.
package vga_pkg;

  localparam int H_ACTIVE = 1280;
  localparam int H_TOTAL  = 1680;
  localparam int V_ACTIVE = 800;
  localparam int V_TOTAL  = 828;

  localparam int DATA_W = 15;
  localparam int ADDR_W = 11;   // 2**ADDR_W must cover H_ACTIVE
  localparam int LINE_W = 10;
  localparam int POS_W  = 15;

  // Pixel word layout {r[14:10], g[9:5], b[4:0]}
  typedef struct packed {
    logic [4:0] r;
    logic [4:0] g;
    logic [4:0] b;
  } rgb555_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_DONE = 2'd2
  } fill_state_e;

endpackage

// File: rtl/vga_line_buffer_if.sv
// Interface: vga_line_buffer_if
// Line-fetch link between the line buffer and the upstream pixel source.
//   line_req  : one-cycle pulse, start fetching line line_num
//   line_num  : line being fetched, held until the next line_req
//   in_valid  : source has a pixel word
//   in_ready  : buffer accepts the word this cycle
//   in_data   : RGB555 pixel word
// Modports: master = the line buffer (issues requests, accepts data),
//           slave  = the pixel source.
interface vga_line_buffer_if;
  import vga_pkg::*;

  logic              line_req;
  logic [LINE_W-1:0] line_num;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;

  modport master (
    output line_req, line_num, in_ready,
    input  in_valid, in_data
  );

  modport slave (
    input  line_req, line_num, in_ready,
    output in_valid, in_data
  );

endinterface

// File: rtl/vga_line_ram.sv
// Module: vga_line_ram
// Simple dual-port line RAM: two banks of DEPTH words, one write port and one
// registered read port. The address MSB selects the bank.
//   pixel_clk : clock
//   we        : write enable
//   wr_addr   : {bank, word} write address
//   wr_data   : write data
//   rd_addr   : {bank, word} read address
//   rd_data   : read data, valid the cycle after rd_addr
module vga_line_ram
  import vga_pkg::*;
#(
  parameter int DEPTH = H_ACTIVE,
  parameter int AW    = ADDR_W,
  parameter int DW    = DATA_W
) (
  input  logic          pixel_clk,
  input  logic          we,
  input  logic [AW:0]   wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic [AW:0]   rd_addr,
  output logic [DW-1:0] rd_data
);

  logic [DW-1:0] mem [2][DEPTH];

  // NOTE: no reset on the array or its read register -- a reset would stop
  // block-RAM inference; the consumer masks rd_data until it is meaningful.
  always_ff @(posedge pixel_clk) begin
    if (we) begin
      mem[wr_addr[AW]][wr_addr[AW-1:0]] <= wr_data;
    end
    rd_data <= mem[rd_addr[AW]][rd_addr[AW-1:0]];
  end

endmodule

// File: rtl/vga_line_buffer.sv
// Module: vga_line_buffer
// Ping-pong scanline buffer ahead of the VGA pixel output stage. Fetches the
// next line from the upstream source while the current line is replayed from
// the other bank, indexed by the timing generator's hpos/vpos.
//   pixel_clk       : clock
//   rst_n           : asynchronous active-low reset
//   hpos, vpos      : timing generator counters
//   blank           : active-high blanking
//   up              : line-fetch link (line_req/line_num, in_valid/in_ready/in_data)
//   out_r/g/b       : blank-masked pixel, one cycle after hpos
//   underrun        : sticky, a line started before its fetch completed
module vga_line_buffer
  import vga_pkg::*;
(
  input  logic               pixel_clk,
  input  logic               rst_n,
  input  logic [POS_W-1:0]   hpos,
  input  logic [POS_W-1:0]   vpos,
  input  logic               blank,
  vga_line_buffer_if.master  up,
  output logic [4:0]         out_r,
  output logic [4:0]         out_g,
  output logic [4:0]         out_b,
  output logic               underrun
);

  localparam logic [POS_W-1:0]  H_LAST_POS = POS_W'(H_ACTIVE);
  localparam logic [POS_W-1:0]  V_LAST_REQ = POS_W'(V_ACTIVE - 1);
  localparam logic [POS_W-1:0]  V_WRAP     = POS_W'(V_TOTAL - 1);
  localparam logic [ADDR_W-1:0] WR_LAST    = ADDR_W'(H_ACTIVE - 1);

  fill_state_e       state;
  logic [ADDR_W-1:0] wr_addr;
  logic [ADDR_W-1:0] rd_addr;
  logic [LINE_W-1:0] next_line;
  logic              ls;
  logic              accept;
  logic              last_accept;
  logic              blank_q;
  logic [DATA_W-1:0] rd_data;
  rgb555_t           pix;

  // Line-start: fetch vpos+1 during active lines except the last, and
  // line 0 on the final blanking line so it is ready when the frame begins.
  // NOTE: every output of always_comb gets a value on every path, else a latch is inferred.
  always_comb begin
    ls        = 1'b0;
    next_line = '0;
    if (hpos == '0) begin
      if (vpos < V_LAST_REQ) begin
        ls        = 1'b1;
        next_line = vpos[LINE_W-1:0] + 1'b1;
      end else if (vpos == V_WRAP) begin
        ls        = 1'b1;
      end
    end
  end

  assign up.in_ready  = (state == ST_FILL);
  assign accept       = up.in_valid && up.in_ready;
  assign last_accept  = accept && (wr_addr == WR_LAST);

  // Beyond the visible width the read address parks at 0; blank masks it.
  assign rd_addr = (hpos < H_LAST_POS) ? hpos[ADDR_W-1:0] : '0;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      wr_addr     <= '0;
      up.line_req <= 1'b0;
      up.line_num <= '0;
      underrun    <= 1'b0;
    end else begin
      up.line_req <= ls;
      if (ls) begin
        // A final word landing on the same edge still completes its line.
        if ((state == ST_FILL) && !last_accept) begin
          underrun <= 1'b1;
        end
        state       <= ST_FILL;
        wr_addr     <= '0;
        up.line_num <= next_line;
      end else if (accept) begin
        if (last_accept) begin
          state <= ST_DONE;
        end else begin
          wr_addr <= wr_addr + 1'b1;
        end
      end
    end
  end

  // Blank is delayed to line up with the RAM read register.
  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      blank_q <= 1'b1;
    end else begin
      blank_q <= blank;
    end
  end

  vga_line_ram u_ram (
    .pixel_clk (pixel_clk),
    .we        (accept),
    .wr_addr   ({up.line_num[0], wr_addr}),
    .wr_data   (up.in_data),
    .rd_addr   ({vpos[0], rd_addr}),
    .rd_data   (rd_data)
  );

  assign pix   = rd_data;
  assign out_r = blank_q ? 5'd0 : pix.r;
  assign out_g = blank_q ? 5'd0 : pix.g;
  assign out_b = blank_q ? 5'd0 : pix.b;

endmodule

// File: tb/tb_vga_line_buffer.sv
// Testbench: tb_vga_line_buffer
// Directed scenarios for vga_line_buffer: reset, line fill and replay,
// backpressure, blanking, underrun with stale data, reset mid-fill, and the
// final-word-on-line-start corner.
module tb_vga_line_buffer;
  import vga_pkg::*;

  logic        pixel_clk = 1'b0;
  logic        rst_n;
  logic [14:0] hpos;
  logic [14:0] vpos;
  logic        blank;
  logic [4:0]  out_r;
  logic [4:0]  out_g;
  logic [4:0]  out_b;
  logic        underrun;

  int n_pass  = 0;
  int n_total = 0;

  vga_line_buffer_if up ();

  vga_line_buffer dut (
    .pixel_clk (pixel_clk),
    .rst_n     (rst_n),
    .hpos      (hpos),
    .vpos      (vpos),
    .blank     (blank),
    .up        (up.master),
    .out_r     (out_r),
    .out_g     (out_g),
    .out_b     (out_b),
    .underrun  (underrun)
  );

  always #5 pixel_clk = ~pixel_clk;

  task automatic tick;
    @(posedge pixel_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic check_pix(input string tag, input logic [14:0] exp);
    check(tag, 32'({out_r, out_g, out_b}), 32'(exp));
  endtask

  // Present a timing position for one edge; the pixel is visible afterwards.
  task automatic show(input logic [14:0] y, input logic [14:0] x, input logic b);
    vpos  = y;
    hpos  = x;
    blank = b;
    tick();
  endtask

  // Fire a line-start at (y, 0) and check the resulting request.
  task automatic start_line(input string tag, input logic [14:0] y, input logic [9:0] exp_num);
    up.in_valid = 1'b0;
    vpos = y;
    hpos = 15'd0;
    tick();
    check({tag, "_req"}, 32'(up.line_req), 32'd1);
    check({tag, "_num"}, 32'(up.line_num), 32'(exp_num));
    check({tag, "_ready"}, 32'(up.in_ready), 32'd1);
    hpos = 15'd1300;
  endtask

  // Stream n words of value base+k; with gaps, in_valid idles every other cycle.
  task automatic stream(input int n, input logic [14:0] base, input bit gaps);
    hpos = 15'd1300;
    for (int k = 0; k < n; k++) begin
      if (gaps) begin
        up.in_valid = 1'b0;
        up.in_data  = 15'h7fff;
        tick();
      end
      up.in_valid = 1'b1;
      up.in_data  = base + 15'(k);
      tick();
    end
    up.in_valid = 1'b0;
  endtask

  initial begin
    // Reset with line-start conditions and random upstream activity present.
    rst_n       = 1'b0;
    hpos        = 15'd0;
    vpos        = 15'd827;
    blank       = 1'b1;
    up.in_valid = 1'b0;
    up.in_data  = '0;
    for (int i = 0; i < 4; i++) begin
      up.in_valid = 1'($urandom_range(0, 1));
      up.in_data  = 15'($urandom);
      tick();
    end
    check_pix("reset_out", 15'd0);
    check("reset_ready", 32'(up.in_ready), 32'd0);
    check("reset_req", 32'(up.line_req), 32'd0);
    check("reset_underrun", 32'(underrun), 32'd0);

    up.in_valid = 1'b0;
    hpos  = 15'd1300;
    rst_n = 1'b1;
    tick();
    check("idle_ready", 32'(up.in_ready), 32'd0);
    check("idle_req", 32'(up.line_req), 32'd0);

    // Line 0: fetched on the last blanking line, ramp data.
    start_line("line0", 15'd827, 10'd0);
    tick();
    check("req_pulse_one_cycle", 32'(up.line_req), 32'd0);
    stream(1280, 15'd0, 1'b0);
    check("line0_done_ready", 32'(up.in_ready), 32'd0);
    show(15'd0, 15'd5, 1'b0);
    check_pix("line0_px5", 15'h0005);
    show(15'd0, 15'd1279, 1'b0);
    check_pix("line0_px1279", 15'd1279);

    // Line 1 with in_valid toggling every cycle.
    start_line("line1", 15'd0, 10'd1);
    stream(1280, 15'd0, 1'b1);
    check("line1_done_ready", 32'(up.in_ready), 32'd0);
    show(15'd1, 15'd7, 1'b0);
    check_pix("line1_px7", 15'd7);
    show(15'd1, 15'd1023, 1'b0);
    check_pix("line1_px1023", 15'd1023);
    show(15'd0, 15'd100, 1'b0);
    check_pix("line0_bank_intact", 15'd100);

    // Blanking masks the output whatever the RAM holds.
    show(15'd1, 15'd10, 1'b1);
    check_pix("blank_active_px", 15'd0);
    show(15'd1, 15'd1300, 1'b1);
    check_pix("blank_hpos", 15'd0);
    show(15'd805, 15'd10, 1'b1);
    check_pix("blank_vpos", 15'd0);
    show(15'd1, 15'd10, 1'b0);
    check_pix("unblank_px10", 15'd10);

    // Line 2 complete, line 3 short by 280 words.
    start_line("line2", 15'd1, 10'd2);
    stream(1280, 15'h2000, 1'b0);
    start_line("line3", 15'd2, 10'd3);
    check("line2_no_underrun", 32'(underrun), 32'd0);
    stream(1000, 15'h1000, 1'b0);
    start_line("line4", 15'd3, 10'd4);
    check("line3_underrun", 32'(underrun), 32'd1);
    show(15'd3, 15'd999, 1'b0);
    check_pix("line3_px999_new", 15'h1000 + 15'd999);
    show(15'd3, 15'd1000, 1'b0);
    check_pix("line3_px1000_stale", 15'd1000);
    show(15'd3, 15'd1279, 1'b0);
    check_pix("line3_px1279_stale", 15'd1279);
    show(15'd2, 15'd500, 1'b0);
    check_pix("line2_px500", 15'h2000 + 15'd500);

    // Reset while line 4 is filling: abandoned, idle until the next line-start.
    hpos  = 15'd1300;
    rst_n = 1'b0;
    #2;
    check("midfill_reset_ready", 32'(up.in_ready), 32'd0);
    check("midfill_reset_underrun", 32'(underrun), 32'd0);
    up.in_valid = 1'b1;
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    check("after_reset_stays_idle", 32'(up.in_ready), 32'd0);
    check("after_reset_no_req", 32'(up.line_req), 32'd0);
    up.in_valid = 1'b0;

    // Final word accepted on the same edge as the next line-start.
    start_line("edge_line0", 15'd827, 10'd0);
    stream(1279, 15'd0, 1'b0);
    up.in_valid = 1'b1;
    up.in_data  = 15'd1279;
    vpos = 15'd0;
    hpos = 15'd0;
    tick();
    check("edge_underrun", 32'(underrun), 32'd0);
    check("edge_req", 32'(up.line_req), 32'd1);
    check("edge_num", 32'(up.line_num), 32'd1);
    check("edge_refill", 32'(up.in_ready), 32'd1);
    hpos = 15'd1300;
    up.in_data = 15'h0abc;
    tick();
    up.in_valid = 1'b0;
    show(15'd1, 15'd1300, 1'b0);     // rd_addr parks at 0 past the visible width
    check_pix("edge_restart_addr0", 15'h0abc);
    show(15'd1, 15'd1, 1'b0);
    check_pix("edge_addr1_untouched", 15'h1001);
    show(15'd0, 15'd1279, 1'b0);
    check_pix("edge_final_word", 15'd1279);
    check("edge_underrun_end", 32'(underrun), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
